// File: rtl/spi_slave_if.sv
// spi_slave_if: SPI pins plus TX/RX handshake bundle for spi_slave.
interface spi_slave_if #(parameter int DATA_WIDTH = 8);
   logic                  sclk;
   logic                  slaveSelect;
   logic                  slaveDataIn;
   logic                  slaveDataOut;
   logic [DATA_WIDTH-1:0] txData;
   logic                  txLoad;
   logic                  txReady;
   logic [DATA_WIDTH-1:0] rxData;
   logic                  rxValid;
   logic                  rxAck;
   logic                  overrun;
   logic                  underrun;
   modport slave (
      input  sclk, slaveSelect, slaveDataIn, txData, txLoad, rxAck,
      output slaveDataOut, txReady, rxData, rxValid, overrun, underrun
   );
   modport master (
      output sclk, slaveSelect, slaveDataIn, txData, txLoad, rxAck,
      input  slaveDataOut, txReady, rxData, rxValid, overrun, underrun
   );
endinterface

// File: rtl/spi_slave.sv
// spi_slave: mode-0 SPI slave oversampled on clk, with one-deep TX buffer and RX register.
module spi_slave #(
   parameter int                    DATA_WIDTH  = 8,
   parameter int                    SYNC_STAGES = 2,
   parameter logic [DATA_WIDTH-1:0] IDLE_FILL   = '1
) (
   input logic        clk,
   input logic        rst,
   spi_slave_if.slave bus
);
   localparam int            CW   = $clog2(DATA_WIDTH);
   localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);
   typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_e;
   state_e                 state_q;
   logic [SYNC_STAGES-1:0] sclk_sync_q, ss_sync_q, mosi_sync_q;
   logic                   sclk_prev_q, ss_prev_q, miso_q;
   logic                   tx_ready_q, rx_valid_q, overrun_q, underrun_q;
   logic [CW-1:0]          cnt_q;
   logic [DATA_WIDTH-1:0]  tx_buf_q, rx_data_q, rx_shift_d, tx_load_d;
   logic [DATA_WIDTH-2:0]  tx_shift_q, rx_shift_q;
   logic                   sclk_s, ss_s, mosi_s, rise, fall;
   // Equal synchroniser depth on all three pins keeps MOSI aligned with the detected SCLK edge.
   assign sclk_s     = sclk_sync_q[SYNC_STAGES-1];
   assign ss_s       = ss_sync_q[SYNC_STAGES-1];
   assign mosi_s     = mosi_sync_q[SYNC_STAGES-1];
   assign rise       = sclk_s & ~sclk_prev_q;
   assign fall       = ~sclk_s & sclk_prev_q;
   assign rx_shift_d = {rx_shift_q, mosi_s};
   assign tx_load_d  = tx_ready_q ? IDLE_FILL : tx_buf_q;
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         sclk_sync_q <= '0;
         ss_sync_q   <= '0;
         mosi_sync_q <= '0;
         sclk_prev_q <= 1'b0;
         ss_prev_q   <= 1'b0;
         miso_q      <= 1'b0;
         tx_ready_q  <= 1'b1;
         rx_valid_q  <= 1'b0;
         overrun_q   <= 1'b0;
         underrun_q  <= 1'b0;
         cnt_q       <= '0;
         tx_buf_q    <= '0;
         rx_data_q   <= '0;
         tx_shift_q  <= '0;
         rx_shift_q  <= '0;
      end else begin
         sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], bus.sclk};
         ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], bus.slaveSelect};
         mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], bus.slaveDataIn};
         sclk_prev_q <= sclk_s;
         ss_prev_q   <= ss_s;
         if (bus.txLoad && tx_ready_q) begin
            tx_buf_q   <= bus.txData;
            tx_ready_q <= 1'b0;
         end
         if (bus.rxAck) rx_valid_q <= 1'b0;
         if (!ss_s) begin
            state_q <= IDLE;
            miso_q  <= 1'b0;
            cnt_q   <= '0;
         end else begin
            case (state_q)
               IDLE: state_q <= ss_prev_q ? IDLE : LOAD;
               LOAD: begin
                  tx_shift_q <= tx_load_d[DATA_WIDTH-2:0];
                  miso_q     <= tx_load_d[DATA_WIDTH-1];
                  if (tx_ready_q) underrun_q <= 1'b1;
                  else tx_ready_q <= 1'b1;
                  cnt_q   <= '0;
                  state_q <= SHIFT;
               end
               SHIFT: begin
                  if (rise) begin
                     rx_shift_q <= rx_shift_d[DATA_WIDTH-2:0];
                     cnt_q      <= cnt_q + 1'b1;
                     if (cnt_q == LAST) begin
                        rx_data_q  <= rx_shift_d;
                        rx_valid_q <= 1'b1;
                        if (rx_valid_q && !bus.rxAck) overrun_q <= 1'b1;
                        state_q <= LOAD;
                     end
                  end else if (fall && cnt_q != '0) begin
                     tx_shift_q <= tx_shift_q << 1;
                     miso_q     <= tx_shift_q[DATA_WIDTH-2];
                  end
               end
               default: state_q <= IDLE;
            endcase
         end
      end
   end
   assign bus.slaveDataOut = miso_q;
   assign bus.txReady      = tx_ready_q;
   assign bus.rxData       = rx_data_q;
   assign bus.rxValid      = rx_valid_q;
   assign bus.overrun      = overrun_q;
   assign bus.underrun     = underrun_q;
endmodule

// File: tb/tb_spi_slave.sv
// tb_spi_slave: directed SPI master stimulus with an RX scoreboard monitor for spi_slave.
module tb_spi_slave;
   localparam int HALF = 6;
   localparam int SS   = 2;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   int         vectors = 0;
   int         miscompares = 0;
   logic [7:0] rxq[$];
   logic       mon_v = 1'b0;
   logic [7:0] mon_d = '0;
   logic [7:0] mon_exp;
   int         mon_age = 0;
   spi_slave_if bus ();
   spi_slave #(.DATA_WIDTH(8), .SYNC_STAGES(SS), .IDLE_FILL(8'hFF)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );
   always #5 clk = ~clk;
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask
   task automatic load_tx(input logic [7:0] d);
      bus.txData = d;
      bus.txLoad = 1'b1;
      @(negedge clk);
      bus.txLoad = 1'b0;
      chk("tx_ready_low_after_load", 32'(bus.txReady), 32'd0);
   endtask
   task automatic ack();
      bus.rxAck = 1'b1;
      @(negedge clk);
      bus.rxAck = 1'b0;
      chk("rx_valid_cleared_by_ack", 32'(bus.rxValid), 32'd0);
   endtask
   task automatic sel_on();
      bus.slaveSelect = 1'b1;
      repeat (HALF) @(negedge clk);
   endtask
   task automatic sel_off();
      repeat (HALF) @(negedge clk);
      bus.slaveSelect = 1'b0;
      repeat (HALF) @(negedge clk);
   endtask
   // Master side of one byte: MOSI changes with the fall, MISO is captured at the rise.
   task automatic xfer(input logic [7:0] mo, input logic [7:0] exp_mi, input int ack_dly, input int nbits);
      logic [7:0] got;
      got = '0;
      for (int i = 7; i >= 8 - nbits; i--) begin
         bus.slaveDataIn = mo[i];
         repeat (HALF) @(negedge clk);
         got[i] = bus.slaveDataOut;
         bus.sclk = 1'b1;
         if (i == 0) rxq.push_back(mo);
         for (int c = 0; c < HALF; c++) begin
            @(negedge clk);
            bus.rxAck = (i == 0 && ack_dly != 0 && c == ack_dly - 1);
         end
         bus.sclk = 1'b0;
      end
      if (nbits == 8) chk("miso_byte", 32'(got), 32'(exp_mi));
   endtask
   initial begin
      forever begin
         @(negedge clk);
         if (bus.rxValid && (!mon_v || bus.rxData != mon_d)) begin
            if (rxq.size() == 0) begin
               vectors++;
               miscompares++;
               $display("FAIL rx_unexpected: got %0h expected no byte", bus.rxData);
            end else begin
               mon_exp = rxq.pop_front();
               chk("rx_data", 32'(bus.rxData), 32'(mon_exp));
            end
            mon_age = 0;
         end else if (rxq.size() != 0) begin
            mon_age++;
            if (mon_age > SS + 3) begin
               mon_exp = rxq.pop_front();
               vectors++;
               miscompares++;
               $display("FAIL rx_timeout: got no rxValid expected %0h", mon_exp);
               mon_age = 0;
            end
         end
         mon_v = bus.rxValid;
         mon_d = bus.rxData;
      end
   end
   initial begin
      repeat (100000) @(posedge clk);
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1);
   end
   initial begin
      bus.sclk = 1'b0;
      bus.slaveSelect = 1'b0;
      bus.slaveDataIn = 1'b0;
      bus.txData = '0;
      bus.txLoad = 1'b0;
      bus.rxAck = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      chk("reset_miso", 32'(bus.slaveDataOut), 32'd0);
      chk("reset_tx_ready", 32'(bus.txReady), 32'd1);
      chk("reset_rx_valid", 32'(bus.rxValid), 32'd0);
      chk("reset_overrun", 32'(bus.overrun), 32'd0);
      chk("reset_underrun", 32'(bus.underrun), 32'd0);
      for (int i = 0; i < 8; i++) begin
         bus.slaveDataIn = i[0];
         bus.sclk = 1'b1;
         repeat (HALF) @(negedge clk);
         bus.sclk = 1'b0;
         repeat (HALF) @(negedge clk);
      end
      chk("deselected_miso", 32'(bus.slaveDataOut), 32'd0);
      chk("deselected_rx_valid", 32'(bus.rxValid), 32'd0);
      chk("deselected_underrun", 32'(bus.underrun), 32'd0);
      // single byte, plus a load attempt while the buffer is full
      load_tx(8'hA5);
      bus.txData = 8'h00;
      bus.txLoad = 1'b1;
      @(negedge clk);
      bus.txLoad = 1'b0;
      chk("tx_ready_full_ignores_load", 32'(bus.txReady), 32'd0);
      sel_on();
      chk("tx_ready_after_load_state", 32'(bus.txReady), 32'd1);
      xfer(8'h3C, 8'hA5, 0, 8);
      sel_off();
      ack();
      // back-to-back with the next byte buffered during the first
      load_tx(8'h5A);
      sel_on();
      load_tx(8'h81);
      xfer(8'h11, 8'h5A, 4, 8);
      xfer(8'h22, 8'h81, 0, 8);
      sel_off();
      chk("b2b_overrun", 32'(bus.overrun), 32'd0);
      ack();
      // abort after four bits, then a clean byte
      load_tx(8'hC3);
      sel_on();
      xfer(8'hF0, 8'h00, 0, 4);
      sel_off();
      chk("abort_rx_valid", 32'(bus.rxValid), 32'd0);
      chk("abort_tx_lost", 32'(bus.txReady), 32'd1);
      load_tx(8'h69);
      sel_on();
      xfer(8'h0F, 8'h69, 0, 8);
      sel_off();
      // rxAck lands on the completion cycle of the next byte
      load_tx(8'h77);
      sel_on();
      xfer(8'hE7, 8'h77, SS, 8);
      sel_off();
      chk("ack_collision_rx_valid", 32'(bus.rxValid), 32'd1);
      chk("ack_collision_overrun", 32'(bus.overrun), 32'd0);
      ack();
      // txLoad lands on the LOAD cycle with an empty buffer
      bus.slaveSelect = 1'b1;
      repeat (SS + 1) @(negedge clk);
      bus.txData = 8'hB4;
      bus.txLoad = 1'b1;
      @(negedge clk);
      bus.txLoad = 1'b0;
      repeat (HALF - SS - 2) @(negedge clk);
      chk("load_collision_underrun", 32'(bus.underrun), 32'd1);
      chk("load_collision_buffered", 32'(bus.txReady), 32'd0);
      xfer(8'hD2, 8'hFF, 4, 8);
      xfer(8'hE1, 8'hB4, 0, 8);
      sel_off();
      chk("load_collision_overrun", 32'(bus.overrun), 32'd0);
      ack();
      // reset mid-byte
      load_tx(8'h5C);
      sel_on();
      xfer(8'hA1, 8'h00, 0, 4);
      rst = 1'b1;
      bus.slaveSelect = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      chk("midrst_miso", 32'(bus.slaveDataOut), 32'd0);
      chk("midrst_tx_ready", 32'(bus.txReady), 32'd1);
      chk("midrst_rx_data", 32'(bus.rxData), 32'd0);
      chk("midrst_rx_valid", 32'(bus.rxValid), 32'd0);
      chk("midrst_overrun", 32'(bus.overrun), 32'd0);
      chk("midrst_underrun", 32'(bus.underrun), 32'd0);
      load_tx(8'h3E);
      sel_on();
      chk("loaded_byte_no_underrun", 32'(bus.underrun), 32'd0);
      xfer(8'h99, 8'h3E, 0, 8);
      sel_off();
      ack();
      // empty buffer, two bytes, no acknowledge
      sel_on();
      xfer(8'h33, 8'hFF, 0, 8);
      xfer(8'h44, 8'hFF, 0, 8);
      sel_off();
      chk("overrun_set", 32'(bus.overrun), 32'd1);
      chk("underrun_set", 32'(bus.underrun), 32'd1);
      chk("overrun_rx_data", 32'(bus.rxData), 32'h44);
      repeat (20) @(negedge clk);
      chk("rx_queue_drained", 32'(rxq.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
